// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencing front-end.
// Holds the controller state enum and the $rstatus exception codes.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    localparam logic [4:0]  RSTATUS_REG        = 5'd30;
    localparam logic [31:0] RSTATUS_MULT_OVF   = 32'd4;
    localparam logic [31:0] RSTATUS_DIV_ZERO   = 32'd5;
    localparam logic [31:0] RSTATUS_MD_TIMEOUT = 32'd6;

    // Exception code depends only on which operation was in flight.
    function automatic logic [31:0] md_exc_code(input logic is_div);
        return is_div ? RSTATUS_DIV_ZERO : RSTATUS_MULT_OVF;
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// BUSY-cycle watchdog: counts while enabled, clears otherwise, and flags the
// final permitted cycle so the controller can leave BUSY on the next edge.
module md_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam logic [5:0] LAST_CNT = 6'(TIMEOUT_CYCLES - 1);

    logic [5:0] cnt_q;
    logic [5:0] cnt_d;

    always_comb begin
        cnt_d = count_en_i ? cnt_q + 6'd1 : 6'd0;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= 6'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_en_i & (cnt_q == LAST_CNT);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and multdiv: accept, one-cycle start pulse, stall
// until RDY, then valid/ready writeback. Optional watchdog under MULTDIV_TIMEOUT_EN.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_mult,
    input  logic        issue_is_div,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    md_state_e   state_q, state_d;
    logic        op_div_q, op_div_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        accept;
    logic        timeout_hit;

`ifdef MULTDIV_TIMEOUT_EN
    md_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i      (clock),
        .srst_i     (reset),
        .count_en_i (state_q == ST_BUSY),
        .expired_o  (timeout_hit)
    );
`else
    // No watchdog: BUSY waits for RDY indefinitely.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign accept = issue_valid & (issue_is_mult ^ issue_is_div) & ~flush;

    always_comb begin
        state_d   = state_q;
        op_div_d  = op_div_q;
        rd_d      = rd_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_div_d = issue_is_div;
                    rd_d     = issue_rd;
                    opa_d    = issue_opA;
                    opb_d    = issue_opB;
                    state_d  = ST_START;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                // RDY is only ever looked at here, so stale RDY elsewhere is harmless.
                if (md_resultRDY) begin
                    wb_rd_d   = md_exception ? RSTATUS_REG : rd_q;
                    wb_data_d = md_exception ? md_exc_code(op_div_q) : md_result;
                    state_d   = ST_DONE;
                end else if (timeout_hit) begin
                    wb_rd_d   = RSTATUS_REG;
                    wb_data_d = RSTATUS_MD_TIMEOUT;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_div_q  <= 1'b0;
            rd_q      <= 5'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_div_q  <= op_div_d;
            rd_q      <= rd_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Start pulse is withheld when the operation is being killed this cycle.
    assign md_ctrl_MULT = (state_q == ST_START) & ~op_div_q & ~flush & ~reset;
    assign md_ctrl_DIV  = (state_q == ST_START) &  op_div_q & ~flush & ~reset;

    assign stall = ((state_q == ST_IDLE) & accept)
                 | (state_q == ST_START)
                 | (state_q == ST_BUSY)
                 | ((state_q == ST_DONE) & ~wb_ready);

    assign md_operandA = opa_q;
    assign md_operandB = opb_q;
    assign wb_valid    = (state_q == ST_DONE);
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed scoreboard bench for multdiv_ctrl with a behavioural multdiv model.
// The timeout scenario runs only when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_is_mult, issue_is_div;
    logic [31:0] issue_opA, issue_opB;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_result = 32'd0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;
    logic        stall, wb_valid, wb_ready, busy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] sb[$];

    // multdiv model state
    int          mdk = 1;
    logic        md_hang = 1'b0;
    logic        pulse_seen = 1'b0;
    logic        pend = 1'b0;
    int          rem = 0;
    logic [31:0] m_a, m_b;
    logic        m_div;
    int          n_mult_pulses = 0;
    int          n_div_pulses = 0;
    longint      prod;

    multdiv_ctrl #(.TIMEOUT_CYCLES(40)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_is_mult(issue_is_mult),
        .issue_is_div (issue_is_div),
        .issue_opA    (issue_opA),
        .issue_opB    (issue_opB),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            pulse_seen = 1'b1;
            m_a   = md_operandA;
            m_b   = md_operandB;
            m_div = md_ctrl_DIV;
            if (md_ctrl_MULT) n_mult_pulses++;
            if (md_ctrl_DIV)  n_div_pulses++;
        end
    end

    always @(posedge clock) begin
        #2;
        md_resultRDY = 1'b0;
        if (pulse_seen) begin
            pulse_seen = 1'b0;
            pend = 1'b1;
            rem  = mdk;
        end
        if (pend && !md_hang) begin
            rem--;
            if (rem == 0) begin
                pend = 1'b0;
                md_resultRDY = 1'b1;
                if (m_div) begin
                    md_exception = (m_b == 32'd0);
                    md_result = (m_b == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(m_a) / $signed(m_b));
                end else begin
                    prod = longint'($signed(m_a)) * longint'($signed(m_b));
                    md_exception = (prod != longint'($signed(prod[31:0])));
                    md_result = prod[31:0];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        issue_valid = 1'b1; issue_is_mult = m; issue_is_div = d;
        issue_opA = a; issue_opB = b; issue_rd = rd;
    endtask

    task automatic idle_issue();
        issue_valid = 1'b0; issue_is_mult = 1'b0; issue_is_div = 1'b0;
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_stall"}, stall, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_wb_valid"}, wb_valid, 0);
        chk({p, "_wb_rd"}, wb_rd, 0);
        chk({p, "_wb_data"}, wb_data, 0);
        chk({p, "_opA"}, md_operandA, 0);
        chk({p, "_opB"}, md_operandB, 0);
        chk({p, "_ctrl"}, {md_ctrl_MULT, md_ctrl_DIV}, 0);
    endtask

    // Called at a drive point; returns mid-cycle of the handshake cycle.
    task automatic wait_wb(input string tag, input int limit, output int waited);
        logic [36:0] e;
        waited = -1;
        for (int i = 0; i < limit; i++) begin
            #3;
            if (wb_valid) begin
                waited = i;
                break;
            end
            chk({tag, "_stall_wait"}, stall, 1);
            next();
        end
        if (waited < 0) begin
            chk({tag, "_wb_valid_timeout"}, wb_valid, 1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected_wb"}, wb_valid, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wb_rd"}, wb_rd, e[36:32]);
            chk({tag, "_wb_data"}, wb_data, e[31:0]);
            chk({tag, "_stall_hs"}, stall, 0);
        end
    endtask

    initial begin
        int n, p_m, p_d;
        logic seen_wb, seen_rdy;
        reset = 1'b1; flush = 1'b0; wb_ready = 1'b1;
        issue_opA = 0; issue_opB = 0; issue_rd = 0;
        idle_issue();
        repeat (2) next();
        #3;
        reset_checks("reset");

        // multiply 7*6, K=1 -> minimum occupancy
        next(); reset = 1'b0; mdk = 1; p_m = n_mult_pulses; p_d = n_div_pulses;
        issue(1, 0, 32'd7, 32'd6, 5'd5); sb.push_back({5'd5, 32'd42});
        #3; chk("mul_acc_stall", stall, 1);
        next(); idle_issue();
        #3; chk("mul_start_pulse", md_ctrl_MULT, 1);
        chk("mul_start_nodiv", md_ctrl_DIV, 0);
        chk("mul_opA", md_operandA, 7);
        next(); wait_wb("mul", 20, n);
        chk("mul_latency", n, 1);
        chk("mul_pulse_count", n_mult_pulses - p_m, 1);
        chk("mul_no_div_pulse", n_div_pulses - p_d, 0);
        next(); #3; chk("mul_idle_after", busy, 0);

        // divide by zero, K=3
        next(); mdk = 3; p_m = n_mult_pulses; p_d = n_div_pulses;
        issue(0, 1, 32'd100, 32'd0, 5'd6); sb.push_back({5'd30, 32'd5});
        next(); idle_issue();
        #3; chk("dz_start_pulse", md_ctrl_DIV, 1);
        next(); wait_wb("dz", 20, n);
        chk("dz_latency", n, 3);
        chk("dz_div_pulses", n_div_pulses - p_d, 1);
        chk("dz_no_mult_pulse", n_mult_pulses - p_m, 0);

        // multiply overflow
        next(); mdk = 2;
        issue(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd7); sb.push_back({5'd30, 32'd4});
        next(); idle_issue();
        next(); wait_wb("ovf", 20, n);

        // backpressure: hold wb_ready low for 3 DONE cycles
        next(); mdk = 2;
        issue(1, 0, 32'd3, 32'd4, 5'd9); sb.push_back({5'd9, 32'd12});
        next(); idle_issue(); wb_ready = 1'b0;
        n = 0;
        while (!wb_valid && n < 20) begin next(); #3; n++; end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin next(); #3; end
            chk("bp_valid", wb_valid, 1);
            chk("bp_rd", wb_rd, 9);
            chk("bp_data", wb_data, 12);
            chk("bp_stall", stall, 1);
        end
        next(); wb_ready = 1'b1;
        wait_wb("bp_hs", 1, n);
        next(); mdk = 1;
        issue(0, 1, 32'd9, 32'd3, 5'd11); sb.push_back({5'd11, 32'd3});
        #3; chk("bp_b2b_accept", stall, 1);
        next(); idle_issue();
        #3; chk("bp_b2b_divpulse", md_ctrl_DIV, 1);
        next(); wait_wb("b2b_div", 20, n);

        // invalid select combinations
        next(); issue(1, 1, 32'd1, 32'd1, 5'd1);
        #3; chk("sel_both_stall", stall, 0);
        next(); issue(0, 0, 32'd1, 32'd1, 5'd1);
        #3; chk("sel_both_busy", busy, 0); chk("sel_none_stall", stall, 0);
        next(); idle_issue();
        #3; chk("sel_none_busy", busy, 0);

        // flush in BUSY, later RDY must be ignored
        next(); mdk = 4;
        issue(1, 0, 32'd2, 32'd3, 5'd3);
        next(); idle_issue();
        next(); flush = 1'b1;
        #3; chk("fl_in_busy", busy, 1);
        next(); flush = 1'b0;
        #3; chk("fl_idle", busy, 0); chk("fl_wb_valid", wb_valid, 0);
        seen_wb = 1'b0; seen_rdy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            next(); #3;
            seen_wb  = seen_wb | wb_valid;
            seen_rdy = seen_rdy | md_resultRDY;
        end
        chk("fl_no_wb", seen_wb, 0);
        chk("fl_late_rdy", seen_rdy, 1);
        next(); mdk = 2;
        issue(1, 0, 32'hFFFF_FFFB, 32'd4, 5'd4); sb.push_back({5'd4, 32'hFFFF_FFEC});
        next(); idle_issue();
        next(); wait_wb("fl_next", 20, n);

        // reset during START
        next(); p_m = n_mult_pulses;
        issue(1, 0, 32'd1, 32'd1, 5'd1);
        next(); idle_issue(); reset = 1'b1;
        #3; chk("rst_start_nopulse", md_ctrl_MULT, 0);
        next(); reset = 1'b0;
        #3; reset_checks("rst_mid");
        repeat (4) next();
        #3; chk("rst_no_pulse_seen", n_mult_pulses - p_m, 0);

`ifdef MULTDIV_TIMEOUT_EN
        next(); md_hang = 1'b1;
        issue(0, 1, 32'd8, 32'd2, 5'd2); sb.push_back({5'd30, 32'd6});
        next(); idle_issue();
        next(); wait_wb("tmo", 60, n);
        chk("tmo_busy_cycles", n, 40);
        md_hang = 1'b0; pend = 1'b0;
`endif

        next(); #3;
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing front-end for the multi-cycle multiply/divide unit, sitting between the execute stage and `multdiv`. It accepts a mult/div instruction from execute, holds stable operands, and issues a single-cycle start pulse. It stalls the pipeline until `data_resultRDY`, then presents the result for writeback with a valid/ready handshake. Arithmetic exceptions become a `$rstatus` write.

## Interface
- `TIMEOUT_CYCLES`, 40: watchdog limit, counted in BUSY cycles; only used with `MULTDIV_TIMEOUT_EN`.
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `issue_valid`, in, 1: execute holds a mult/div instruction.
- `issue_is_mult`, `issue_is_div`, in, 1 each: operation select.
- `issue_opA`, `issue_opB`, in, 32: operands.
- `issue_rd`, in, 5: destination register.
- `flush`, in, 1: kill any in-flight operation.
- `md_operandA`, `md_operandB`, out, 32: registered operands to `multdiv`.
- `md_ctrl_MULT`, `md_ctrl_DIV`, out, 1: one-cycle start pulses to `multdiv`.
- `md_result`, in, 32: `multdiv` result.
- `md_exception`, in, 1: `multdiv` exception flag.
- `md_resultRDY`, in, 1: `multdiv` ready flag.
- `stall`, out, 1: freeze fetch/decode/execute.
- `wb_valid`, out, 1: writeback request.
- `wb_ready`, in, 1: writeback accepts the request.
- `wb_rd`, out, 5: writeback destination.
- `wb_data`, out, 32: writeback data.
- `busy`, out, 1: state is not IDLE.

## Operation
- States: IDLE, START, BUSY, DONE. A 2-bit state register resets to IDLE.
- **Accept:** in IDLE, accept when `issue_valid & (issue_is_mult ^ issue_is_div) & ~flush`.
  - On accept, latch opA, opB, rd and op (1 = div) into registers, then go to START.
  - Both selects high, or both low, is ignored: no accept, no stall.
- **START:** exactly one of `md_ctrl_MULT` / `md_ctrl_DIV` is high for this single cycle, chosen by the latched op. Next state is BUSY.
- **BUSY:** wait for `md_resultRDY`.
  - `md_resultRDY` is sampled only in BUSY. A stale RDY during START is ignored.
  - On RDY, capture the writeback registers and go to DONE.
  - Normal result: `wb_rd` = latched rd, `wb_data` = `md_result`.
  - Exception (`md_exception` = 1): `wb_rd` = 30, `wb_data` = 4 for mult overflow or 5 for divide-by-zero.
- **DONE:** `wb_valid` = 1, and `wb_rd`/`wb_data` are held stable until `wb_ready`. Then go to IDLE.
- **Stall rule:** `stall` = `(IDLE & accept) | START | BUSY | (DONE & ~wb_ready)`. The issuing instruction leaves execute in the same cycle the handshake completes.
- **Flush:** forces IDLE from any state on the next edge.
  - The result is discarded and `wb_valid` drops.
  - No accept occurs in a flush cycle.
  - A start pulse scheduled for START is suppressed if flush is asserted in that cycle.
- `md_operandA`/`md_operandB` change only on accept, so they stay stable for the whole operation.
- **Reset values:**
  - state = IDLE.
  - `md_ctrl_*` = 0.
  - `md_operand*` = 0.
  - `stall` = 0, `busy` = 0.
  - `wb_valid` = 0, `wb_rd` = 0, `wb_data` = 0.
  - Watchdog count = 0.
- **Reset mid-operation:** identical to flush, and also clears all registers. `multdiv` is left to finish internally; its output is ignored because it is never sampled outside BUSY.

## Timing
- Cycle 0: accept, with `stall` high combinationally.
- Cycle 1: START pulse.
- Cycles 2..N: BUSY. RDY is first sampleable at cycle 2.
- The cycle after RDY: DONE with `wb_valid` high.
- Minimum occupancy is 4 cycles: accept, START, 1 BUSY cycle, then DONE with `wb_ready` already high.
- A back-to-back issue is accepted on the cycle immediately after DONE completes.
- With `multdiv` needing K cycles after the pulse, total = K + 3 cycles when `wb_ready` is always high.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - A 6-bit watchdog counts BUSY cycles and clears on leaving BUSY.
  - On reaching `TIMEOUT_CYCLES` without RDY, go to DONE with `wb_rd` = 30 and `wb_data` = 6.
- `MULTDIV_TIMEOUT_EN` undefined: no counter logic, and BUSY waits indefinitely.

## Structure
- Shared package `multdiv_pkg`:
  - State enum.
  - `RSTATUS_REG` = 30.
  - `RSTATUS_MULT_OVF` = 4, `RSTATUS_DIV_ZERO` = 5, `RSTATUS_MD_TIMEOUT` = 6.
- One sub-module: `md_watchdog`, containing the counter, compare and clear. It is instantiated only under `MULTDIV_TIMEOUT_EN`.

## Test plan
- **Multiply:** mult 7 × 6 → one `md_ctrl_MULT` pulse at cycle 1, then `wb_valid` with `wb_rd` = issue_rd and `wb_data` = 42. `stall` is high from cycle 0 through the handshake.
- **Divide by zero:** div 100 ÷ 0 → `md_ctrl_DIV` pulse only, then writeback with `wb_rd` = 30 and `wb_data` = 5.
- **Multiply overflow:** mult 0x10000 × 0x10000 → writeback with `wb_rd` = 30 and `wb_data` = 4.
- **Backpressure:** hold `wb_ready` = 0 for 3 cycles after DONE → `wb_valid`, `wb_rd` and `wb_data` stay constant and `stall` stays high. The cycle `wb_ready` rises, `stall` drops; the next cycle a new div 9 ÷ 3 is accepted and produces 3.
- **Flush and reset:** assert `flush` in BUSY → next cycle is IDLE, a later RDY produces no `wb_valid`, and the next issue works normally. Assert `reset` in START → all outputs reach their reset values next cycle and no pulse is emitted.
- **Selects and timeout:** `issue_is_mult` = `issue_is_div` = 1 → no accept, `stall` = 0. With `MULTDIV_TIMEOUT_EN` and a `multdiv` model that never raises RDY → DONE after 40 BUSY cycles with `wb_data` = 6.
